// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM encodings, access sizes, byte-enable patterns and
// the small helpers that turn a decoded access into bus-side controls.
package mem_access_unit_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   typedef enum logic [1:0] {
      SizeWord = 2'd0,
      SizeHalf = 2'd1,
      SizeByte = 2'd2
   } accSize_t;

   // Big-endian lanes: lane 0 is bits 31:24, i.e. enable bit 3.
   localparam logic [3:0] BE_BYTE0 = 4'b1000;
   localparam logic [3:0] BE_BYTE1 = 4'b0100;
   localparam logic [3:0] BE_BYTE2 = 4'b0010;
   localparam logic [3:0] BE_BYTE3 = 4'b0001;
   localparam logic [3:0] BE_HALF0 = 4'b1100;
   localparam logic [3:0] BE_HALF1 = 4'b0011;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   function automatic logic isMisaligned(accSize_t size, logic [1:0] offset);
      case (size)
         SizeHalf: return offset[0];
         SizeWord: return offset != 2'b00;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byteEnable(accSize_t size, logic [1:0] offset);
      case (size)
         SizeByte: begin
            case (offset)
               2'd0:    return BE_BYTE0;
               2'd1:    return BE_BYTE1;
               2'd2:    return BE_BYTE2;
               default: return BE_BYTE3;
            endcase
         end
         SizeHalf: return offset[1] ? BE_HALF1 : BE_HALF0;
         default:  return BE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] storeLanes(accSize_t size, logic [31:0] data);
      case (size)
         SizeByte: return {4{data[7:0]}};
         SizeHalf: return {2{data[15:0]}};
         default:  return data;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the addressed byte/halfword out of a big-endian bus word
// and sign- or zero-extends it to 32 bits.
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] memData,
   input  logic [1:0]  offset,
   input  accSize_t    size,
   input  logic        signExt,
   output logic [31:0] result
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   always_comb begin
      case (offset)
         2'd0:    byteLane = memData[31:24];
         2'd1:    byteLane = memData[23:16];
         2'd2:    byteLane = memData[15:8];
         default: byteLane = memData[7:0];
      endcase
      halfLane = offset[1] ? memData[15:0] : memData[31:16];
      case (size)
         SizeByte: result = {{24{signExt & byteLane[7]}}, byteLane};
         SizeHalf: result = {{16{signExt & halfLane[15]}}, halfLane};
         default:  result = memData;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one decoded access as a handshaked word-bus transaction,
// stalling the pipeline until the memory answers or the access times out.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemByte,
   input  logic        MemHalf,
   input  logic        MemSignExt,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        Flush,
   input  logic        Mem_Hold,
   input  logic [31:0] DataMem_In,
   input  logic        DataMem_Ready,
   output logic [29:0] DataMem_Addr,
   output logic        DataMem_Read,
   output logic [3:0]  DataMem_Write,
   output logic [31:0] DataMem_Out,
   output logic [31:0] ReadData,
   output logic        Mem_Stall,
   output logic        Exc_AdEL,
   output logic        Exc_AdES,
   output logic        Bus_Error
);

   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]           stateQ, stateD;
   logic [CNT_WIDTH-1:0] cntQ, cntD;
   logic [29:0]          addrQ, addrD;
   logic [3:0]           beQ, beD;
   logic [31:0]          dataQ, dataD;
   logic                 readQ, readD;
   accSize_t             sizeQ, sizeD;
   logic [1:0]           offsetQ, offsetD;
   logic                 signQ, signD;
   logic [31:0]          readDataQ, readDataD;
   logic                 adelQ, adelD, adesQ, adesD, busErrQ, busErrD;

   accSize_t    reqSize;
   logic        req, isLoad, misaligned;
   logic [31:0] loadResult;

   assign req        = (MemRead | MemWrite) & ~Flush;
   assign isLoad     = ~MemWrite;  // a store wins when both strobes are set
   assign reqSize    = MemByte ? SizeByte : (MemHalf ? SizeHalf : SizeWord);
   assign misaligned = isMisaligned(reqSize, Address[1:0]);

   load_align uLoadAlign (
      .memData (DataMem_In),
      .offset  (offsetQ),
      .size    (sizeQ),
      .signExt (signQ),
      .result  (loadResult)
   );

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      addrD     = addrQ;
      beD       = beQ;
      dataD     = dataQ;
      readD     = readQ;
      sizeD     = sizeQ;
      offsetD   = offsetQ;
      signD     = signQ;
      readDataD = readDataQ;
      adelD     = 1'b0;
      adesD     = 1'b0;
      busErrD   = 1'b0;
      case (stateQ)
         IDLE: begin
            if (req && misaligned) begin
               adelD = isLoad;
               adesD = ~isLoad;
            end else if (req) begin
               stateD  = ACCESS;
               cntD    = '0;
               addrD   = Address[31:2];
               beD     = isLoad ? 4'b0000 : byteEnable(reqSize, Address[1:0]);
               dataD   = storeLanes(reqSize, WriteData);
               readD   = isLoad;
               sizeD   = reqSize;
               offsetD = Address[1:0];
               signD   = MemSignExt;
            end
         end
         ACCESS: begin
            if (DataMem_Ready) begin
               stateD = DONE;
               if (readQ) readDataD = loadResult;
            end else if (cntQ == CntLast) begin
               stateD    = DONE;
               busErrD   = 1'b1;
               readDataD = '0;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         DONE: begin
            if (!Mem_Hold) stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ    <= IDLE;
         cntQ      <= '0;
         addrQ     <= '0;
         beQ       <= '0;
         dataQ     <= '0;
         readQ     <= 1'b0;
         sizeQ     <= SizeWord;
         offsetQ   <= '0;
         signQ     <= 1'b0;
         readDataQ <= '0;
         adelQ     <= 1'b0;
         adesQ     <= 1'b0;
         busErrQ   <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         addrQ     <= addrD;
         beQ       <= beD;
         dataQ     <= dataD;
         readQ     <= readD;
         sizeQ     <= sizeD;
         offsetQ   <= offsetD;
         signQ     <= signD;
         readDataQ <= readDataD;
         adelQ     <= adelD;
         adesQ     <= adesD;
         busErrQ   <= busErrD;
      end
   end

   assign DataMem_Addr  = addrQ;
   assign DataMem_Read  = (stateQ == ACCESS) & readQ;
   assign DataMem_Write = (stateQ == ACCESS) ? beQ : 4'b0000;
   assign DataMem_Out   = dataQ;
   assign ReadData      = readDataQ;
   // Stall starts in the issue cycle so EX/MEM holds the instruction while it is registered.
   assign Mem_Stall     = (stateQ == ACCESS) | ((stateQ == IDLE) & req & ~misaligned);
   assign Exc_AdEL      = adelQ;
   assign Exc_AdES      = adesQ;
   assign Bus_Error     = busErrQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level model predicts every output
// each cycle, plus directed accesses with hand-computed literal results.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset, MemRead, MemWrite, MemByte, MemHalf, MemSignExt;
   logic [31:0] Address, WriteData, DataMem_In;
   logic        Flush, Mem_Hold, DataMem_Ready;
   logic [29:0] DataMem_Addr;
   logic        DataMem_Read;
   logic [3:0]  DataMem_Write;
   logic [31:0] DataMem_Out, ReadData;
   logic        Mem_Stall, Exc_AdEL, Exc_AdES, Bus_Error;

   always #5 clock = ~clock;

   mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemByte(MemByte), .MemHalf(MemHalf), .MemSignExt(MemSignExt), .Address(Address),
      .WriteData(WriteData), .Flush(Flush), .Mem_Hold(Mem_Hold), .DataMem_In(DataMem_In),
      .DataMem_Ready(DataMem_Ready), .DataMem_Addr(DataMem_Addr), .DataMem_Read(DataMem_Read),
      .DataMem_Write(DataMem_Write), .DataMem_Out(DataMem_Out), .ReadData(ReadData),
      .Mem_Stall(Mem_Stall), .Exc_AdEL(Exc_AdEL), .Exc_AdES(Exc_AdES), .Bus_Error(Bus_Error)
   );

   int total = 0;
   int bad   = 0;

   // Per-cycle expectations written by the driver, consumed by the compare process.
   logic        chkEn = 1'b0;
   logic        eStall, eRead, eAdEL, eAdES, eBus, eBusValid, eOutValid;
   logic [3:0]  eWrite;
   logic [29:0] eAddr;
   logic [31:0] eOut, eRd;
   logic        forceFlush = 1'b0;

   int          stallCnt, readCnt, writeCnt, adelCnt, adesCnt, busCnt;
   logic [3:0]  capBe;
   logic [31:0] capOut;
   logic [29:0] capAddr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rules, sizes: 0 byte, 1 half, 2 word.
   function automatic logic mMis(int sz, logic [1:0] off);
      return (sz == 1 && off[0]) || (sz == 2 && off != 2'b00);
   endfunction

   function automatic logic [3:0] mBe(int sz, logic [1:0] off);
      if (sz == 0) return 4'b1000 >> off;
      if (sz == 1) return 4'b1100 >> off;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] mLanes(int sz, logic [31:0] w);
      if (sz == 0) return {4{w[7:0]}};
      if (sz == 1) return {2{w[15:0]}};
      return w;
   endfunction

   function automatic logic [31:0] mLoad(int sz, logic [1:0] off, logic [31:0] d, logic sx);
      logic [31:0] t;
      int unsigned sh;
      if (sz == 2) return d;
      t  = d << (8 * int'(off));
      sh = (sz == 0) ? 24 : 16;
      if (sx) return $signed(t) >>> sh;
      return t >> sh;
   endfunction

   always @(negedge clock) begin
      if (chkEn) begin
         check("Mem_Stall", 32'(Mem_Stall), 32'(eStall));
         check("DataMem_Read", 32'(DataMem_Read), 32'(eRead));
         check("DataMem_Write", 32'(DataMem_Write), 32'(eWrite));
         check("Exc_AdEL", 32'(Exc_AdEL), 32'(eAdEL));
         check("Exc_AdES", 32'(Exc_AdES), 32'(eAdES));
         check("Bus_Error", 32'(Bus_Error), 32'(eBus));
         check("ReadData", ReadData, eRd);
         if (eBusValid) check("DataMem_Addr", 32'(DataMem_Addr), 32'(eAddr));
         if (eOutValid) check("DataMem_Out", DataMem_Out, eOut);
         if (Mem_Stall) stallCnt++;
         if (DataMem_Read) readCnt++;
         if (DataMem_Write != 4'b0000) begin
            writeCnt++;
            capBe  = DataMem_Write;
            capOut = DataMem_Out;
         end
         if (DataMem_Read || DataMem_Write != 4'b0000) capAddr = DataMem_Addr;
         if (Exc_AdEL) adelCnt++;
         if (Exc_AdES) adesCnt++;
         if (Bus_Error) busCnt++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   task automatic clearCaps();
      stallCnt = 0; readCnt = 0; writeCnt = 0; adelCnt = 0; adesCnt = 0; busCnt = 0;
      capBe = '0; capOut = '0; capAddr = '0;
   endtask

   task automatic setIdleExp();
      eStall = 1'b0; eRead = 1'b0; eWrite = 4'b0000; eAdEL = 1'b0; eAdES = 1'b0;
      eBus = 1'b0; eBusValid = 1'b0; eOutValid = 1'b0; eAddr = '0; eOut = '0;
   endtask

   task automatic driveIdle();
      MemRead = 1'b0; MemWrite = 1'b0;
      MemByte = 1'($urandom); MemHalf = 1'($urandom); MemSignExt = 1'($urandom);
      Address = $urandom; WriteData = $urandom; Flush = 1'($urandom);
      Mem_Hold = 1'($urandom); DataMem_In = $urandom; DataMem_Ready = 1'($urandom);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         driveIdle();
         setIdleExp();
      end
   endtask

   // One instruction reaching MEM; inputs stay held while the pipeline is stalled.
   task automatic runTxn(input logic rd, input logic wr, input logic bf, input logic hf,
                         input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdat, input int waits, input int holds,
                         input logic flushIss, input int resetAt);
      int   sz, k;
      logic ld, mis, isReq, tout, fin;
      sz    = bf ? 0 : (hf ? 1 : 2);
      ld    = rd & ~wr;
      isReq = (rd | wr) & ~flushIss;
      mis   = mMis(sz, addr[1:0]);
      tick();
      MemRead = rd; MemWrite = wr; MemByte = bf; MemHalf = hf; MemSignExt = sx;
      Address = addr; WriteData = wd; Flush = flushIss;
      Mem_Hold = 1'($urandom); DataMem_In = $urandom; DataMem_Ready = 1'($urandom);
      setIdleExp();
      eStall = isReq & ~mis;
      if (!isReq) return;
      if (mis) begin
         tick();
         driveIdle();
         setIdleExp();
         eAdEL = ld;
         eAdES = ~ld;
         return;
      end
      k = 0; tout = 1'b0; fin = 1'b0;
      while (!fin) begin
         tick();
         Flush = forceFlush | 1'($urandom);
         Mem_Hold = 1'($urandom);
         DataMem_Ready = (k == waits);
         DataMem_In = (k == waits) ? rdat : $urandom;
         reset = (k == resetAt);
         setIdleExp();
         eStall = 1'b1; eRead = ld; eWrite = ld ? 4'b0000 : mBe(sz, addr[1:0]);
         eBusValid = 1'b1; eAddr = addr[31:2];
         eOutValid = ~ld; eOut = mLanes(sz, wd);
         if (k == resetAt) begin
            tick();
            reset = 1'b0;
            driveIdle();
            setIdleExp();
            eRd = '0; eBusValid = 1'b1; eOutValid = 1'b1;
            return;
         end
         if (k == waits) fin = 1'b1;
         else if (k == TO - 1) begin
            tout = 1'b1;
            fin  = 1'b1;
         end else k++;
      end
      for (int h = 0; h <= holds; h++) begin
         tick();
         Mem_Hold = (h < holds);
         Flush = 1'($urandom); DataMem_Ready = 1'($urandom); DataMem_In = $urandom;
         setIdleExp();
         if (h == 0) begin
            eBus = tout;
            if (tout) eRd = '0;
            else if (ld) eRd = mLoad(sz, addr[1:0], rdat, sx);
         end
      end
   endtask

   initial begin
      setIdleExp();
      eRd = '0;
      reset = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'b0; MemHalf = 1'b0; MemSignExt = 1'b0;
      Address = '0; WriteData = '0; Flush = 1'b0; Mem_Hold = 1'b0;
      DataMem_In = '0; DataMem_Ready = 1'b0;
      clearCaps();
      tick();
      chkEn = 1'b1;
      eBusValid = 1'b1; eOutValid = 1'b1;
      tick();
      reset = 1'b0;
      idleCycles(2);

      // LW 0x1004, zero-wait
      clearCaps();
      runTxn(1, 0, 0, 0, 0, 32'h0000_1004, 32'h0, 32'hDEADBEEF, 0, 0, 0, -1);
      idleCycles(1); settle();
      check("lw_addr", 32'(capAddr), 32'h0000_0401);
      check("lw_read_cycles", readCnt, 1);
      check("lw_stall_cycles", stallCnt, 2);
      check("lw_data", ReadData, 32'hDEADBEEF);

      // LB / LBU at offset 1
      runTxn(1, 0, 1, 0, 1, 32'h0000_2001, 32'h0, 32'h1280_3456, 1, 0, 0, -1);
      idleCycles(1); settle();
      check("lb_sext", ReadData, 32'hFFFF_FF80);
      runTxn(1, 0, 1, 0, 0, 32'h0000_2001, 32'h0, 32'h1280_3456, 0, 1, 0, -1);
      idleCycles(1); settle();
      check("lbu_zext", ReadData, 32'h0000_0080);

      // SH offset 2, SB offset 3
      clearCaps();
      runTxn(0, 1, 0, 1, 0, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 0, 0, 0, -1);
      idleCycles(1); settle();
      check("sh_be", 32'(capBe), 32'h3);
      check("sh_out", capOut, 32'hABCD_ABCD);
      check("st_keeps_rdata", ReadData, 32'h0000_0080);
      clearCaps();
      runTxn(0, 1, 1, 0, 0, 32'h0000_3003, 32'h0000_0077, 32'h0, 1, 0, 0, -1);
      idleCycles(1); settle();
      check("sb_be", 32'(capBe), 32'h1);

      // misaligned LW / SH
      clearCaps();
      runTxn(1, 0, 0, 0, 0, 32'h0000_1006, 32'h0, 32'h0, 0, 0, 0, -1);
      idleCycles(2); settle();
      check("adel_pulses", adelCnt, 1);
      check("adel_no_read", readCnt, 0);
      check("adel_no_stall", stallCnt, 0);
      clearCaps();
      runTxn(0, 1, 0, 1, 0, 32'h0000_3001, 32'h1234, 32'h0, 0, 0, 0, -1);
      idleCycles(2); settle();
      check("ades_pulses", adesCnt, 1);
      check("ades_no_write", writeCnt, 0);

      // timeout
      clearCaps();
      runTxn(1, 0, 0, 0, 0, 32'h0000_2000, 32'h0, 32'h5555_AAAA, 10, 0, 0, -1);
      idleCycles(1); settle();
      check("to_bus_error", busCnt, 1);
      check("to_access_cycles", readCnt, TO);
      check("to_rdata", ReadData, 32'h0);

      // store under Flush during ACCESS
      clearCaps();
      forceFlush = 1'b1;
      runTxn(0, 1, 0, 0, 0, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 2, 0, 0, -1);
      forceFlush = 1'b0;
      idleCycles(1); settle();
      check("flush_st_cycles", writeCnt, 3);
      check("flush_st_be", 32'(capBe), 32'hF);
      check("flush_st_no_err", busCnt, 0);

      // reset during ACCESS
      runTxn(1, 0, 0, 0, 0, 32'h0000_0100, 32'h0, 32'h1357_2468, 1, 0, 0, -1);
      clearCaps();
      runTxn(1, 0, 0, 0, 0, 32'h0000_0080, 32'h0, 32'h0, 5, 0, 0, 1);
      idleCycles(1); settle();
      check("rst_access_cycles", readCnt, 2);
      check("rst_rdata", ReadData, 32'h0);

      // Mem_Hold in DONE
      clearCaps();
      runTxn(1, 0, 0, 0, 0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 0, 3, 0, -1);
      idleCycles(1); settle();
      check("hold_single_issue", readCnt, 1);
      check("hold_rdata", ReadData, 32'hCAFE_F00D);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic st, rd, bf, hf;
         int   sz, rstAt;
         st = ($urandom_range(0, 9) < 4);
         rd = ~st | ($urandom_range(0, 7) == 0);
         sz = $urandom_range(0, 2);
         bf = (sz == 0);
         hf = (sz == 1);
         rstAt = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
         runTxn(rd, st, bf, hf, 1'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 2), ($urandom_range(0, 7) == 0), rstAt);
         idleCycles($urandom_range(0, 2));
      end
      idleCycles(2);
      settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
